// File: rtl/dmem_pkg.sv
// Shared types and helpers for the rv32i data-memory responder.
// Holds the FSM state type, funct3 access codes and the misalignment rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size comes from funct3[1:0]: 00 byte, 01 half, 1x word.
  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      funct3[1]:                   m = |addr_lo;
      (funct3[1:0] == F3_H[1:0]): m = addr_lo[0];
      default:                     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane logic: load extract/extend, store merge, misalign flag.
// Ports: funct3, addr_lo, old_word, wr_data in; load_data, merged_word, misaligned out.
// Build option: DMEM_MISALIGN_CHECK_EN enables misalignment detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wr_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word,
  output logic        misaligned
);

  logic       is_b;
  logic       is_h;
  logic       is_w;
  logic       sx;
  logic [1:0] lo;
  logic [7:0] b;
  logic [15:0] h;

  always_comb begin
    is_b = funct3[1:0] == F3_B[1:0];
    is_h = funct3[1:0] == F3_H[1:0];
    is_w = funct3[1];
    sx   = ~funct3[2];
`ifdef DMEM_MISALIGN_CHECK_EN
    misaligned = is_misaligned(funct3, addr_lo);
    lo         = addr_lo;
`else
    // Without checking, drop the low bits so the access is aligned.
    misaligned = 1'b0;
    lo         = addr_lo & {~is_w, is_b};
`endif
    b = old_word[{lo, 3'b000} +: 8];
    h = old_word[{lo[1], 4'b0000} +: 16];
    load_data   = old_word;
    merged_word = old_word;
    unique case (1'b1)
      is_b: begin
        load_data = {{24{sx & b[7]}}, b};
        merged_word[{lo, 3'b000} +: 8] = wr_data[7:0];
      end
      is_h: begin
        load_data = {{16{sx & h[15]}}, h};
        merged_word[{lo[1], 4'b0000} +: 16] = wr_data[15:0];
      end
      is_w: begin
        load_data   = old_word;
        merged_word = wr_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_CYCLES wait states, ready pulse.
// Ports: clk, reset, rd, wr, addr, wr_data, funct3 in; rd_data, ready, busy, misaligned out.
// Build option: DMEM_MISALIGN_CHECK_EN enables misalignment detection.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  output logic              misaligned
);

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  dmem_state_t state;
  dmem_state_t nxt;

  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_f3;
  logic              req_st;
  logic              req_ld;

  logic [31:0] mem [WORDS];

  logic              idle;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [2:0]        cur_f3;
  logic              cur_ld;
  logic [31:0]       old_word;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic              lane_mis;

  // With zero wait states the load result is captured straight from
  // the request inputs, so the lane logic sees inputs while idle.
  assign idle      = state == IDLE;
  assign cur_addr  = idle ? addr : req_addr;
  assign cur_wdata = idle ? wr_data : req_wdata;
  assign cur_f3    = idle ? funct3 : req_f3;
  assign cur_ld    = idle ? (rd & ~wr) : req_ld;
  assign old_word  = mem[cur_addr[ADDR_W-1:2]];

  dmem_lane_align u_lane (
    .funct3      (cur_f3),
    .addr_lo     (cur_addr[1:0]),
    .old_word    (old_word),
    .wr_data     (cur_wdata),
    .load_data   (load_data),
    .merged_word (merged_word),
    .misaligned  (lane_mis)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (rd | wr) nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == CW'(1)) nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_f3    <= '0;
      req_st    <= 1'b0;
      req_ld    <= 1'b0;
      rd_data   <= '0;
    end else begin
      state <= nxt;
      if (idle && (rd | wr)) begin
        cnt       <= CW'(WAIT_CYCLES);
        req_addr  <= addr;
        req_wdata <= wr_data;
        req_f3    <= funct3;
        req_st    <= wr;
        req_ld    <= rd & ~wr;
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
      // Load result lands on entry to RESP so it is valid with ready.
      if (nxt == RESP && cur_ld)
        rd_data <= lane_mis ? '0 : load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state == RESP && req_st && !lane_mis)
      mem[req_addr[ADDR_W-1:2]] <= merged_word;
  end

  assign ready      = state == RESP;
  assign busy       = !idle;
  assign misaligned = ready & lane_mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a byte-level memory model.
// Honours DMEM_MISALIGN_CHECK_EN for misalignment expectations.
module tb_dmem_responder;

  localparam int WC = 3;
  localparam int AW = 9;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [31:0]   wr_data;
  logic [2:0]    funct3;
  logic [31:0]   rd_data;
  logic          ready;
  logic          busy;
  logic          misaligned;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_W      (32),
    .ADDR_W      (AW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd         (rd),
    .wr         (wr),
    .addr       (addr),
    .wr_data    (wr_data),
    .funct3     (funct3),
    .rd_data    (rd_data),
    .ready      (ready),
    .busy       (busy),
    .misaligned (misaligned)
  );

  logic [7:0]  mb [512];
  bit          pend;
  int          age;
  logic        m_st;
  logic [8:0]  m_addr;
  logic [31:0] m_d;
  logic [2:0]  m_f3;
  logic [31:0] exp_rd;
  logic        exp_rdy;
  logic        exp_busy;
  logic        exp_mis;

  // Model and per-cycle compare. Inputs and reset change 1ns after the
  // falling edge, so here they still show what the last rising edge saw.
  initial begin
    int n;
    int a;
    bit bad;
    logic [31:0] v;
    for (int i = 0; i < 512; i++) mb[i] = 8'h00;
    pend = 0; age = 0; exp_rd = 0;
    exp_rdy = 0; exp_busy = 0; exp_mis = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0; exp_rd = 0;
        exp_rdy = 0; exp_busy = 0; exp_mis = 0;
      end else begin
        if (pend) begin
          age++;
          if (age > WC + 1) pend = 0;
        end else if (rd | wr) begin
          pend = 1; age = 1;
          m_st = wr; m_addr = addr; m_d = wr_data; m_f3 = funct3;
        end
        exp_busy = pend;
        exp_rdy  = pend && (age == WC + 1);
        exp_mis  = 0;
        if (exp_rdy) begin
          n = (m_f3[1:0] == 2'b00) ? 1 : (m_f3[1:0] == 2'b01) ? 2 : 4;
          a = int'(m_addr);
          bad = (a % n) != 0;
          if (MIS_EN) exp_mis = bad;
          else begin
            bad = 0;
            a = a - (a % n);
          end
          if (m_st) begin
            if (!bad)
              for (int i = 0; i < n; i++) mb[(a + i) % 512] = m_d[8*i +: 8];
          end else begin
            v = 0;
            if (!bad) begin
              for (int i = 0; i < n; i++) v[8*i +: 8] = mb[(a + i) % 512];
              if (n < 4 && !m_f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            end
            exp_rd = v;
          end
        end
      end
      if (chk_on) begin
        tests++;
        if (ready !== exp_rdy) begin
          fails++;
          $display("FAIL cyc_ready got=%b exp=%b t=%0t", ready, exp_rdy, $time);
        end
        tests++;
        if (busy !== exp_busy) begin
          fails++;
          $display("FAIL cyc_busy got=%b exp=%b t=%0t", busy, exp_busy, $time);
        end
        tests++;
        if (misaligned !== exp_mis) begin
          fails++;
          $display("FAIL cyc_mis got=%b exp=%b t=%0t", misaligned, exp_mis, $time);
        end
        tests++;
        if (rd_data !== exp_rd) begin
          fails++;
          $display("FAIL cyc_rd_data got=%h exp=%h t=%0t", rd_data, exp_rd, $time);
        end
      end
    end
  end

  // Called right at a falling edge; returns at a falling edge after one idle cycle.
  task automatic req(input logic r, input logic w, input logic [8:0] a,
                     input logic [31:0] d, input logic [2:0] f, input bit hold,
                     input bit chk, input logic [31:0] exp_v, input logic exp_m,
                     input string nm);
    int n;
    #1;
    rd = r; wr = w; addr = a; wr_data = d; funct3 = f;
    @(negedge clk);
    #1;
    if (!hold) begin
      rd = 0; wr = 0;
      addr = 9'h1AB; wr_data = 32'hBAD0_BAD0; funct3 = 3'b000;
    end
    n = 1;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (hold) begin
      #1;
      rd = 0; wr = 0;
    end
    tests++;
    if (!ready || n != WC + 1) begin
      fails++;
      $display("FAIL %s latency got=%0d exp=%0d ready=%b", nm, n, WC + 1, ready);
    end
    tests++;
    if (misaligned !== exp_m) begin
      fails++;
      $display("FAIL %s misaligned got=%b exp=%b", nm, misaligned, exp_m);
    end
    if (chk) begin
      tests++;
      if (rd_data !== exp_v) begin
        fails++;
        $display("FAIL %s rd_data got=%h exp=%h", nm, rd_data, exp_v);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic [31:0] w10;
    reset = 1; rd = 0; wr = 0; addr = 0; wr_data = 0; funct3 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_on = 1;
    tests++;
    if ({ready, busy, misaligned} !== 3'b000 || rd_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_state got=%b/%h exp=000/00000000",
               {ready, busy, misaligned}, rd_data);
    end
    reset = 0;
    @(negedge clk);

    req(0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 0, 0, 0, "sw_010");
    req(1, 0, 9'h010, 0, 3'b010, 0, 1, 32'hDEADBEEF, 0, "lw_010");
    req(0, 1, 9'h011, 32'hAAAAAA80, 3'b000, 0, 0, 0, 0, "sb_011");
    req(1, 0, 9'h011, 0, 3'b000, 0, 1, 32'hFFFFFF80, 0, "lb_011");
    req(1, 0, 9'h011, 0, 3'b100, 0, 1, 32'h00000080, 0, "lbu_011");
    req(1, 0, 9'h010, 0, 3'b010, 0, 1, 32'hDEAD80EF, 0, "lw_after_sb");
    req(0, 1, 9'h012, 32'h55558001, 3'b001, 0, 0, 0, 0, "sh_012");
    req(1, 0, 9'h012, 0, 3'b001, 0, 1, 32'hFFFF8001, 0, "lh_012");
    req(1, 0, 9'h012, 0, 3'b101, 0, 1, 32'h00008001, 0, "lhu_012");
    req(1, 0, 9'h013, 0, 3'b010, 0, 1, MIS_EN ? 32'h0 : 32'h800180EF,
        MIS_EN, "lw_013_mis");
    req(0, 1, 9'h011, 32'h00001234, 3'b001, 0, 0, 0, MIS_EN, "sh_011_mis");
    w10 = MIS_EN ? 32'h800180EF : 32'h80011234;
    req(1, 0, 9'h010, 0, 3'b010, 0, 1, w10, 0, "lw_after_mis");
    req(1, 0, 9'h010, 0, 3'b111, 0, 1, w10, 0, "f3_111_as_lw");
    req(0, 1, 9'h1FC, 32'hA1B2C3D4, 3'b011, 0, 0, 0, 0, "sw_1fc_f3_011");
    req(1, 0, 9'h1FF, 0, 3'b000, 0, 1, 32'hFFFFFFA1, 0, "lb_1ff");
    req(1, 0, 9'h1FE, 0, 3'b101, 0, 1, 32'h0000A1B2, 0, "lhu_1fe");
    req(1, 0, 9'h1FC, 0, 3'b100, 0, 1, 32'h000000D4, 0, "lbu_1fc");

    req(0, 1, 9'h020, 32'h0, 3'b010, 0, 0, 0, 0, "prefill_020");
    #1;
    rd = 0; wr = 1; addr = 9'h020; wr_data = 32'h12345678; funct3 = 3'b010;
    @(negedge clk);
    #1;
    wr = 0;
    @(negedge clk);
    #1;
    reset = 1;
    @(negedge clk);
    tests++;
    if ({ready, busy, misaligned} !== 3'b000 || rd_data !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset got=%b/%h exp=000/00000000",
               {ready, busy, misaligned}, rd_data);
    end
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    #1;
    reset = 0;
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    tests++;
    if (cnt != 0) begin
      fails++;
      $display("FAIL reset_no_ready got=%0d exp=0", cnt);
    end
    req(1, 0, 9'h020, 0, 3'b010, 0, 1, 32'h0, 0, "lw_020_after_reset");

    req(1, 1, 9'h030, 32'h00000055, 3'b010, 1, 0, 0, 0, "rd_wr_both");
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    tests++;
    if (cnt != 0) begin
      fails++;
      $display("FAIL single_ready got=%0d extra exp=0", cnt);
    end
    req(1, 0, 9'h030, 0, 3'b010, 0, 1, 32'h00000055, 0, "lw_030");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the rv32i core: the memory-side endpoint of the datapath's `rd`/`wr`/`addr`/`wr_data`/`rd_data` port. It accepts one load or store request at a time, holds it through a configurable wait-state counter, and completes it with a one-cycle `ready` pulse. Byte and halfword stores merge into the addressed word. Byte and halfword loads are extracted and sign- or zero-extended per `funct3`.

## Interface
- `DATA_W`, 32, data width; fixed at 32 for rv32i.
- `ADDR_W`, 9, byte-address width; the array holds 2**ADDR_W bytes as 2**(ADDR_W-2) little-endian words.
- `WAIT_CYCLES`, 1, wait states inserted between acceptance and response; 0 is legal.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rd`  in  1  load request.
- `wr`  in  1  store request.
- `addr`  in  ADDR_W  byte address.
- `wr_data`  in  DATA_W  store data; the low byte or halfword is used for SB/SH.
- `funct3`  in  3  access size and signedness (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `rd_data`  out  DATA_W  registered load result.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from acceptance until `ready`; requests are ignored while high.
- `misaligned`  out  1  pulses with `ready` when the access was misaligned.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `rd|wr`, capture `addr`, `wr_data`, `funct3` and the access type. The counter loads `WAIT_CYCLES`. Go to WAIT, or go directly to RESP when `WAIT_CYCLES`=0.
- WAIT: the counter decrements each cycle. When it reaches 1, go to RESP.
- RESP:
  - `ready`=1.
  - A store commits to the array on this cycle's edge.
  - A load drives `rd_data` from the array with extension applied.
  - The next state is always IDLE. Back-to-back requests therefore see one idle cycle minimum.
- `rd` and `wr` both high at acceptance: the store wins and the load is dropped.
- Load extraction:
  - LB/LBU: byte `addr[1:0]`, sign-/zero-extended.
  - LH/LHU: half `addr[1]`, sign-/zero-extended.
  - LW: whole word.
  - Unused codes 011/110/111 are treated as LW.
- Store merge:
  - SB writes byte `addr[1:0]`.
  - SH writes half `addr[1]`.
  - SW writes the whole word.
  - `funct3[1:0]`=11 is treated as SW.
  - The other bytes of the word are preserved.
- Misalignment: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - No array access.
  - `rd_data` is set to 0 for loads.
  - `misaligned`=1 together with `ready`.
- Addresses wrap modulo 2**ADDR_W. There is no out-of-range condition.

## Timing
- Reset values: state IDLE, `ready`=0, `busy`=0, `misaligned`=0, `rd_data`=0, counter 0. Array contents are not reset.
- Request sampled in cycle 0. `busy` is high in cycles 1..WAIT_CYCLES+1. `ready` is high in cycle WAIT_CYCLES+1 only.
- `rd_data` becomes valid in the `ready` cycle. It holds until the next load response or reset; stores do not change it.
- Inputs are don't-care after acceptance until `ready` has been seen.
- Reset asserted mid-operation: the pending request is discarded, a pending store is not committed, and no `ready` is issued.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined: misalignment detection behaves as described in Operation.
- `DMEM_MISALIGN_CHECK_EN` undefined:
  - `misaligned` is tied to 0.
  - Address low bits are masked (`addr[0]` for halfword, `addr[1:0]` for word).
  - The access proceeds on the aligned address.

## Structure
- Package `dmem_pkg` holds:
  - the state enum `dmem_state_t` (IDLE, WAIT, RESP);
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the helper function `is_misaligned(funct3, addr_lo)`.
- Sub-module `dmem_lane_align` (combinational) covers:
  - load lane select and extension;
  - store byte-merge of old word and new data;
  - misalignment flag.
- `dmem_responder` owns the FSM, wait counter, request registers, array and `rd_data` register.

## Test plan
- Reset, then SW `addr`=0x010, `wr_data`=0xDEADBEEF, then LW 0x010 → `rd_data`=0xDEADBEEF; `ready` arrives WAIT_CYCLES+1 cycles after each request.
- SB 0x80 to 0x011, then LB 0x011 → 0xFFFFFF80; LBU 0x011 → 0x00000080; LW 0x010 → 0xDEAD80EF.
- SH 0x8001 to 0x012, then LH 0x012 → 0xFFFF8001; LHU 0x012 → 0x00008001.
- LW 0x013 with `DMEM_MISALIGN_CHECK_EN` → `misaligned`=1 with `ready`, `rd_data`=0, memory unchanged. Without the macro → `misaligned`=0, `rd_data`=word at 0x010.
- SW 0x20 = 0x12345678 with `reset` asserted during WAIT (WAIT_CYCLES=3) → no `ready`, all outputs 0; after reset, LW 0x020 ≠ 0x12345678 (prefill 0).
- `rd`=`wr`=1 at 0x030 with `wr_data`=0x55 (SW); extra requests while `busy` → exactly one `ready`; LW 0x030 → 0x00000055.
